instr_fetch_rom: RTL

- Parametrised successor to the combinational instruction ROM.
- A program counter walks a synchronous, width/depth-generic ROM, and each fetched word sits in a 2-entry output buffer.
- Instructions are handed to the decode stage with a valid/ready handshake.
- Supports fetch stall (run low), back-pressure and branch redirect with flush, so decode can stall without losing or duplicating words.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_fifo.sv | 67 ++++++
 rtl/instr_fetch_rom.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and ROM contents for the instruction fetch block.
package fetch_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 6;
  localparam int unsigned DefResetPc   = 0;
  localparam int unsigned RomWordWidth = 64;

  // ROM word i holds i; callers resize the result to their data width.
  function automatic logic [RomWordWidth-1:0] rom_word(input logic [RomWordWidth-1:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry head-first FIFO; the head slot keeps its last value when the FIFO empties.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop, do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) slot0_d = wdata;
          else                 slot1_d = wdata;
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd2) slot0_d = slot1_q;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = wdata;
          end else begin
            slot0_d = slot1_q;
            slot1_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/instr_fetch_rom.sv
// PC-driven instruction ROM feeding a 2-entry valid/ready buffer with redirect flush.
// Define FETCH_PERF_CNT_EN to add a saturating 16-bit pop counter output (fetch_count).
module instr_fetch_rom
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned RESET_PC   = DefResetPc
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  pc_wrap
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_count
`endif
);

  localparam int unsigned PayloadWidth = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    pc_wrap_q, pc_wrap_d;
  logic [1:0]              count;
  logic [PayloadWidth-1:0] head;
  logic [DATA_WIDTH-1:0]   rom_data;
  logic                    pop, capture;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign capture     = run && !redirect_valid && ((count != 2'd2) || pop);
  assign rom_data    = DATA_WIDTH'(rom_word(RomWordWidth'(pc_q)));

  // Redirect wins over capture; the pc increment wraps naturally since DEPTH = 2**ADDR_WIDTH.
  always_comb begin
    pc_d      = pc_q;
    pc_wrap_d = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (capture) begin
      pc_d      = pc_q + ADDR_WIDTH'(1);
      pc_wrap_d = (pc_q == ADDR_WIDTH'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= ADDR_WIDTH'(RESET_PC);
      pc_wrap_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_wrap_q <= pc_wrap_d;
    end
  end

  fetch_skid_fifo #(
    .WIDTH (PayloadWidth)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, rom_data}),
    .count (count),
    .head  (head)
  );

  assign instr_addr = head[PayloadWidth-1 -: ADDR_WIDTH];
  assign instr_data = head[DATA_WIDTH-1:0];
  assign pc_wrap    = pc_wrap_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 16'd0;
    end else if (pop && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
